// File: rtl/s_mem_arbiter.sv
// Round-robin arbiter sharing the single-port S memory between several requesters.
// Define SMEM_ARB_LOCK_EN to let one requester hold the memory for an uninterrupted swap.
module s_mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_data,
    output logic                      mem_wren,
    input  logic [DATA_W-1:0]         mem_q
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t owner;
    } tag_t;

    idx_t ptr;
    idx_t win;
    idx_t cand;
    logic xfer;
    logic locked;
    idx_t lock_idx;
    tag_t tag_s1;
    tag_t tag_s2;

`ifdef SMEM_ARB_LOCK_EN
    logic lock_vld;
    idx_t lock_own;

    // Ownership is re-evaluated on every edge: only a locking transfer keeps or takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_vld <= 1'b0;
            lock_own <= '0;
        end else begin
            lock_vld <= xfer & lock[win];
            if (xfer) begin
                lock_own <= win;
            end
        end
    end

    // An owner that drops req releases the lock in the same cycle.
    assign locked   = lock_vld & req[lock_own];
    assign lock_idx = lock_own;
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign locked      = 1'b0;
    assign lock_idx    = '0;
`endif

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        gnt  = '0;
        xfer = 1'b0;
        win  = '0;
        cand = '0;
        if (locked) begin
            xfer = 1'b1;
            win  = lock_idx;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = idx_t'((int'(ptr) + i) % NUM_REQ);
                if (!xfer && req[cand]) begin
                    xfer = 1'b1;
                    win  = cand;
                end
            end
        end
        gnt[win] = xfer;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            tag_s1      <= '0;
            tag_s2      <= '0;
            rvalid      <= '0;
            rdata       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            mem_wren <= 1'b0;
            tag_s1   <= '0;
            if (xfer) begin
                ptr         <= (win == idx_t'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                mem_address <= addr[win*ADDR_W +: ADDR_W];
                mem_data    <= wdata[win*DATA_W +: DATA_W];
                mem_wren    <= we[win];
                tag_s1      <= '{valid: ~we[win], owner: win};
            end
            // The RAM latches the address one cycle after the transfer and returns q one cycle later.
            tag_s2 <= tag_s1;
            rvalid <= '0;
            if (tag_s2.valid) begin
                rvalid[tag_s2.owner] <= 1'b1;
                rdata                <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Randomized scoreboard bench for s_mem_arbiter with an attached 256x8 synchronous RAM.
// The reference model follows SMEM_ARB_LOCK_EN the same way the design does.
`timescale 1ns/1ps
module tb_s_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 8;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req     = '0;
    logic [N-1:0]      we      = '0;
    logic [N-1:0]      lock    = '0;
    logic [N*AW-1:0]   addr    = '0;
    logic [N*DW-1:0]   wdata   = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_data;
    logic              mem_wren;
    logic [DW-1:0]     mem_q;

    s_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .we          (we),
        .lock        (lock),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    always #5 clk = ~clk;

    // S memory: synchronous single port, q is the old content at the latched address.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    typedef struct packed {
        logic       we;
        logic       lk;
        logic [7:0] a;
        logic [7:0] d;
    } op_t;

    typedef struct {
        int         owner;
        logic [7:0] data;
        int         due;
    } exp_t;

    op_t        ops [N][$];
    exp_t       sb[$];
    exp_t       popped;
    logic [7:0] m_mem [256];
    int         m_ptr  = 0;
    int         m_lock = -1;
    logic       e_wren = 1'b0;
    logic [7:0] e_addr = '0;
    logic [7:0] e_data = '0;
    logic [N-1:0] took = '0;
    logic [N-1:0] eg;
    int         w;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_op(input int r, input logic wr, input logic lk, input logic [7:0] a, input logic [7:0] d);
        op_t o;
        o.we = wr;
        o.lk = lk;
        o.a  = a;
        o.d  = d;
        ops[r].push_back(o);
    endtask

    // Reference model and monitor, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            m_ptr  = 0;
            m_lock = -1;
            e_wren = 1'b0;
            e_addr = '0;
            e_data = '0;
            took   = '0;
            check("rst_rvalid", rvalid, 0);
            check("rst_rdata", rdata, 0);
            check("rst_mem_wren", mem_wren, 0);
            check("rst_mem_address", mem_address, 0);
            check("rst_mem_data", mem_data, 0);
            check("rst_gnt", gnt, 0);
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("rvalid_owner", rvalid, 32'd1 << sb[0].owner);
                check("rdata", rdata, sb[0].data);
                popped = sb.pop_front();
            end else if (rvalid != '0) begin
                check("rvalid_spurious", rvalid, 0);
            end

            check("mem_wren", mem_wren, e_wren);
            check("mem_address", mem_address, e_addr);
            check("mem_data", mem_data, e_data);

            // Winner: the lock owner if it still requests, otherwise first requester from ptr upward, then from 0.
            w = -1;
`ifdef SMEM_ARB_LOCK_EN
            if (m_lock >= 0 && req[m_lock]) w = m_lock;
`endif
            for (int i = m_ptr; i < N; i++) if (w < 0 && req[i]) w = i;
            for (int i = 0; i < m_ptr; i++) if (w < 0 && req[i]) w = i;

            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            check("gnt", gnt, eg);
            took = req & gnt;

            if (w >= 0) begin
                e_wren = we[w];
                e_addr = addr[w*AW +: AW];
                e_data = wdata[w*DW +: DW];
                if (we[w]) m_mem[e_addr] = e_data;
                else sb.push_back('{w, m_mem[e_addr], cyc + 3});
                m_ptr  = (w + 1) % N;
                m_lock = lock[w] ? w : -1;
            end else begin
                e_wren = 1'b0;
                m_lock = -1;
            end
        end
    end

    // Requesters: present the head of each op queue, retire it after a granted edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (took[i] && ops[i].size() > 0) ops[i].delete(0);
                if (reset_n && ops[i].size() > 0) begin
                    req[i]            = 1'b1;
                    we[i]             = ops[i][0].we;
                    lock[i]           = ops[i][0].lk;
                    addr[i*AW +: AW]  = ops[i][0].a;
                    wdata[i*DW +: DW] = ops[i][0].d;
                end else begin
                    req[i]  = 1'b0;
                    we[i]   = 1'b0;
                    lock[i] = 1'b0;
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((ops[0].size() + ops[1].size() + ops[2].size() + sb.size()) != 0 && n < 2000) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("drain_done", n < 2000, 1);
        repeat (4) @(posedge clk);
        #3;
    endtask

    task automatic wait_took(input int r);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #3;
            if (took[r]) break;
            n++;
        end
        check("took_wait", n < 100, 1);
    endtask

    initial begin
        logic [7:0] vi;
        logic [7:0] vj;
        for (int i = 0; i < 256; i++) begin
            ram[i]   = 8'(i) ^ 8'h5A;
            m_mem[i] = 8'(i) ^ 8'h5A;
        end
        ram[8'h10]   = 8'hA5;
        m_mem[8'h10] = 8'hA5;

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Single read of S[0x10] by requester 1.
        push_op(1, 1'b0, 1'b0, 8'h10, 8'h00);
        drain();

        // Write 0x3C to 0x80 by requester 0, then requester 2 reads it on the next cycle.
        push_op(0, 1'b1, 1'b0, 8'h80, 8'h3C);
        wait_took(0);
        push_op(2, 1'b0, 1'b0, 8'h80, 8'h00);
        drain();

        // Fairness: everyone reads continuously starting from ptr 0.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++)
                push_op(i, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'h00);
        drain();

        // Swap of S[0x20] and S[0x21] by requester 1 while requester 0 keeps reading.
        vi = m_mem[8'h20];
        vj = m_mem[8'h21];
        for (int k = 0; k < 8; k++) push_op(0, 1'b0, 1'b0, 8'h40 + 8'(k), 8'h00);
        push_op(1, 1'b0, 1'b1, 8'h20, 8'h00);
        push_op(1, 1'b0, 1'b1, 8'h21, 8'h00);
        push_op(1, 1'b1, 1'b1, 8'h20, vj);
        push_op(1, 1'b1, 1'b0, 8'h21, vi);
        drain();
        push_op(0, 1'b0, 1'b0, 8'h20, 8'h00);
        push_op(0, 1'b0, 1'b0, 8'h21, 8'h00);
        drain();

        // Random mix of reads, writes and locks on a small address window.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 60; k++)
                push_op(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                        8'h60 + 8'($urandom_range(0, 15)), 8'($urandom));
        drain();

        // Reset one cycle after a read transfer: the read must vanish.
        push_op(2, 1'b0, 1'b0, 8'h10, 8'h00);
        wait_took(2);
        @(posedge clk);
        #2 reset_n = 1'b0;
        for (int i = 0; i < N; i++) ops[i].delete();
        #1;
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_mem_wren", mem_wren, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        for (int i = 0; i < N; i++) push_op(i, 1'b0, 1'b0, 8'h10 + 8'(i), 8'h00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete (checks %0d errors %0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/s_mem_arbiter.md
# s_mem_arbiter

Round-robin arbiter that shares the single-port 256x8 S memory between several requesters: the init, KSA shuffle and PRGA/decrypt FSMs, and parallel key-search lanes. It sits between those FSMs and the s_memory instance. It owns the memory's address, data and write-enable inputs, and returns read data to the correct requester. It supports one access per clock, with fair rotation between requesters and an optional lock so one requester can perform an uninterrupted read-read-write-write swap.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester access request; held until granted
- we  in  NUM_REQ  per-requester write (1) / read (0) qualifier
- lock  in  NUM_REQ  per-requester lock request (used only when SMEM_ARB_LOCK_EN is defined)
- addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_REQ*DATA_W  packed write data, same packing as addr
- gnt  out  NUM_REQ  one-hot combinational accept; transfer occurs when req[i] & gnt[i] at a rising edge
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse marking read data for requester i
- rdata  out  DATA_W  read data, shared by all requesters, meaningful only with rvalid
- mem_address  out  ADDR_W  to s_memory address
- mem_data  out  DATA_W  to s_memory data
- mem_wren  out  1  to s_memory wren
- mem_q  in  DATA_W  from s_memory q; valid one cycle after the RAM latches the address

## Operation
- **gnt generation:** combinational from req, the round-robin pointer and the lock state. At most one bit is high, and gnt[i] is never high without req[i].
- **Round-robin search:** starts at index ptr and wraps modulo NUM_REQ. After a transfer by requester k, ptr <= (k+1) mod NUM_REQ. With no transfer, ptr is unchanged.
- **Transfer registration:** on a transfer edge, mem_address, mem_data and mem_wren are registered from the winner. mem_wren = we of the winner.
- **Idle edge:** mem_wren <= 0. mem_address and mem_data hold their previous values.
- **Read tag pipeline:** a 2-stage pipeline carries {valid, owner index} for read transfers. At stage 2, rdata <= mem_q and rvalid[owner] <= 1 for one cycle.
- **Writes:** produce no rvalid.
- **Ordering:** a read following a write to the same address returns the new data, because the RAM is written before it is read again.
- **Requester side:** may change addr, we and wdata, or drop req, in the cycle after a transfer. Inputs are sampled only on transfer edges.

## Timing
- **Reset values (asynchronous):**
  - gnt follows inputs.
  - rvalid = 0, rdata = 0, mem_address = 0, mem_data = 0, mem_wren = 0.
  - ptr = 0, tag pipeline cleared, lock owner = none.
- **Read latency:**
  - Transfer at edge of cycle t, so mem_* are driven in cycle t+1.
  - RAM latches at edge t+2.
  - rvalid and rdata are asserted in cycle t+3.
- **Throughput:** one transfer per cycle. Back-to-back reads from any mix of requesters give consecutive rvalid pulses in issue order.
- **Simultaneous requests:** the lowest index at or after ptr wins. The others wait with req held and lose nothing.
- **Reset mid-operation:** all in-flight reads are discarded and no rvalid is emitted after reset deassertion. mem_wren drops immediately.
- **Pointer wrap:** after requester NUM_REQ-1 is granted, ptr = 0.

## Configuration
- **SMEM_ARB_LOCK_EN defined:**
  - A transfer by requester k with lock[k]=1 makes k the lock owner. While an owner exists, only the owner can be granted.
  - The lock is released at the owner's next transfer with lock[k]=0, which is still granted, or immediately when req[k] is low.
  - ptr does not advance while locked. On release, ptr <= (k+1) mod NUM_REQ.
- **SMEM_ARB_LOCK_EN undefined:** lock is ignored, pure round-robin, and no lock-owner register is synthesized.

## Test plan
- **Single read:** memory preloaded S[0x10]=0xA5. Requester 1 raises req with we=0, addr=0x10 in cycle 0. Expect gnt[1] in cycle 0, mem_address=0x10 and mem_wren=0 in cycle 1, rvalid=3'b010 and rdata=0xA5 in cycle 3.
- **Fairness:** all three requesters read continuously from ptr=0. Expect the grant sequence 0,1,2,0,1,2. Each rvalid goes to the matching owner 3 cycles after its grant, with no gaps.
- **Write then read:** requester 0 writes 0x3C to 0x80, then requester 2 reads 0x80 on the next cycle. Expect mem_wren=1 for exactly one cycle, then rdata=0x3C with rvalid[2].
- **Lock swap (SMEM_ARB_LOCK_EN):**
  - Stimulus: requester 1 performs read i, read j and write i with lock=1, then write j with lock=0, while requester 0 requests continuously.
  - Expect gnt[0]=0 during all four accesses, gnt[0] in the cycle after the write j, and memory contents swapped.
- **Lock disabled:** the same stimulus without the macro. Expect requester 0 to be granted interleaved with requester 1.
- **Reset mid-read:** assert reset_n=0 one cycle after a read transfer. Expect rvalid=0, mem_wren=0, ptr=0, and no rvalid pulse after release.
